// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 9-bit UART receiver with 16x oversampling and ready/read handshake
// Frame: start(0), 9 data bits LSB first, stop(1); line idles high.
module uart_rx #(
   parameter int CLK_HZ      = 25_000_000,
   parameter int BAUD_RATE   = 9600,
   parameter int SAMPLE_RATE = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   input  logic       read,
   output logic [8:0] data,
   output logic       data_ready,
   output logic       framing_error,
   output logic       overrun_error,
   output logic       busy
);

   localparam int DIVISOR = CLK_HZ / (BAUD_RATE * SAMPLE_RATE);
   localparam int DIV_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic             sync1_q, sync2_q;
   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [3:0]       sample_q, sample_d;
   logic [3:0]       bit_q, bit_d;
   logic [8:0]       shift_q, shift_d;
   logic [8:0]       data_q, data_d;
   logic             ready_q, ready_d;
   logic             ferr_q, ferr_d;
   logic             oerr_q, oerr_d;
   logic             rx_s;
   logic             tick;

   assign rx_s = sync2_q;
   assign tick = (div_q == DIV_LAST);

   always_comb begin
      state_d  = state_q;
      div_d    = '0;
      sample_d = sample_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      data_d   = data_q;
      ready_d  = ready_q & ~read;
      ferr_d   = 1'b0;
      oerr_d   = 1'b0;

      if (state_q != ST_IDLE) begin
         div_d = tick ? '0 : div_q + DIV_W'(1);
         if (tick) begin
            sample_d = sample_q + 4'd1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            sample_d = 4'd0;
            if (!rx_s) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick && sample_q == 4'd7) begin
               sample_d = 4'd0;
               if (!rx_s) begin
                  state_d = ST_DATA;
                  bit_d   = 4'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (tick && sample_q == 4'd15) begin
               shift_d  = {rx_s, shift_q[8:1]};
               bit_d    = bit_q + 4'd1;
               sample_d = 4'd0;
               if (bit_q == 4'd8) begin
                  state_d = ST_STOP;
               end
            end
         end
         default: begin
            // Leave at mid stop bit so the next start edge is caught promptly.
            if (tick && sample_q == 4'd15) begin
               state_d  = ST_IDLE;
               sample_d = 4'd0;
               if (rx_s) begin
                  data_d  = shift_q;
                  ready_d = 1'b1;
                  oerr_d  = ready_q & ~read;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         state_q  <= ST_IDLE;
         div_q    <= '0;
         sample_q <= 4'd0;
         bit_q    <= 4'd0;
         shift_q  <= 9'd0;
         data_q   <= 9'd0;
         ready_q  <= 1'b0;
         ferr_q   <= 1'b0;
         oerr_q   <= 1'b0;
      end else begin
         sync1_q  <= rx;
         sync2_q  <= sync1_q;
         state_q  <= state_d;
         div_q    <= div_d;
         sample_q <= sample_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         ready_q  <= ready_d;
         ferr_q   <= ferr_d;
         oerr_q   <= oerr_d;
      end
   end

   assign data          = data_q;
   assign data_ready    = ready_q;
   assign framing_error = ferr_q;
   assign overrun_error = oerr_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b1;
   logic       read  = 1'b0;
   logic [8:0] data;
   logic       data_ready;
   logic       framing_error;
   logic       overrun_error;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int oe_cnt = 0;
   logic [8:0] exp_q[$];
   logic [8:0] prev_data  = 9'd0;
   logic       prev_ready = 1'b0;

   uart_rx #(.CLK_HZ(1600), .BAUD_RATE(100), .SAMPLE_RATE(16)) dut (
      .clock(clock),
      .reset(reset),
      .rx(rx),
      .read(read),
      .data(data),
      .data_ready(data_ready),
      .framing_error(framing_error),
      .overrun_error(overrun_error),
      .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // A new word is visible when data_ready rises or data changes under it.
   always @(negedge clock) begin
      if (!reset) begin
         if (framing_error) fe_cnt <= fe_cnt + 1;
         if (overrun_error) oe_cnt <= oe_cnt + 1;
         if ((data_ready && !prev_ready) || (data != prev_data)) begin
            if (exp_q.size() == 0) check("sb_pending", 32'(exp_q.size()), 32'd1);
            else                   check("sb_word", 32'(data), 32'(exp_q.pop_front()));
         end
      end
      prev_data  <= data;
      prev_ready <= data_ready;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_frame(input logic [8:0] w, input logic stop_bit, input int max_cyc);
      logic [10:0] fr;
      fr = {stop_bit, w, 1'b0};
      if (stop_bit && max_cyc >= 176) exp_q.push_back(w);
      for (int i = 0; i < 176 && i < max_cyc; i++) begin
         rx = fr[i/16];
         @(posedge clock);
         #1;
      end
      rx = 1'b1;
   endtask

   task automatic pulse_read();
      read = 1'b1;
      cyc(1);
      read = 1'b0;
   endtask

   initial begin
      int k;
      int busy_bad;
      int fe0, oe0;

      cyc(3);
      @(negedge clock);
      check("rst_data", 32'(data), 32'd0);
      check("rst_ready", 32'(data_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ferr", 32'(framing_error), 32'd0);
      check("rst_oerr", 32'(overrun_error), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      cyc(4);

      // Valid frame: ready appears on the 171st edge after the pin falls,
      // i.e. 170 cycles after the first edge that samples the start bit.
      fe0 = fe_cnt; oe0 = oe_cnt; busy_bad = 0; k = 0;
      fork
         send_frame(9'h1A5, 1'b1, 176);
         begin
            while (k < 300) begin
               @(posedge clock);
               k++;
               @(negedge clock);
               if (k >= 3 && k < 171 && !busy) busy_bad++;
               if (data_ready) break;
            end
         end
      join
      check("latency", 32'(k), 32'd171);
      check("busy_hold", 32'(busy_bad), 32'd0);
      check("valid_data", 32'(data), 32'h1A5);
      check("valid_errs", 32'(fe_cnt - fe0 + oe_cnt - oe0), 32'd0);
      pulse_read();
      @(negedge clock);
      check("read_clears", 32'(data_ready), 32'd0);
      cyc(4);

      // Glitch on the start bit
      fe0 = fe_cnt; oe0 = oe_cnt;
      rx = 1'b0;
      cyc(4);
      rx = 1'b1;
      cyc(2);
      @(negedge clock);
      check("glitch_busy", 32'(busy), 32'd1);
      cyc(30);
      @(negedge clock);
      check("glitch_idle", 32'(busy), 32'd0);
      check("glitch_ready", 32'(data_ready), 32'd0);
      check("glitch_errs", 32'(fe_cnt - fe0 + oe_cnt - oe0), 32'd0);

      // Framing error
      fe0 = fe_cnt; oe0 = oe_cnt;
      send_frame(9'h0FF, 1'b0, 176);
      cyc(40);
      check("ferr_pulse", 32'(fe_cnt - fe0), 32'd1);
      check("ferr_data", 32'(data), 32'h1A5);
      check("ferr_ready", 32'(data_ready), 32'd0);
      check("ferr_oerr", 32'(oe_cnt - oe0), 32'd0);

      // Overrun with no read
      fe0 = fe_cnt; oe0 = oe_cnt;
      send_frame(9'h155, 1'b1, 176);
      send_frame(9'h0AA, 1'b1, 176);
      cyc(4);
      check("ovr_pulse", 32'(oe_cnt - oe0), 32'd1);
      check("ovr_data", 32'(data), 32'h0AA);
      check("ovr_ready", 32'(data_ready), 32'd1);
      pulse_read();
      cyc(4);

      // Read coincides with completion of the second word
      oe0 = oe_cnt;
      send_frame(9'h155, 1'b1, 176);
      fork
         send_frame(9'h0AA, 1'b1, 176);
         begin
            repeat (170) @(posedge clock);
            #1;
            read = 1'b1;
            @(posedge clock);
            #1;
            read = 1'b0;
         end
      join
      cyc(2);
      check("simul_no_ovr", 32'(oe_cnt - oe0), 32'd0);
      check("simul_data", 32'(data), 32'h0AA);
      check("simul_ready", 32'(data_ready), 32'd1);
      pulse_read();
      @(negedge clock);
      check("simul_cleared", 32'(data_ready), 32'd0);
      cyc(4);

      // Back-to-back frames; the last word is left unread for the reset test
      fe0 = fe_cnt; oe0 = oe_cnt;
      fork
         begin
            send_frame(9'h001, 1'b1, 176);
            send_frame(9'h100, 1'b1, 176);
            send_frame(9'h1FF, 1'b1, 176);
         end
         begin
            for (int j = 0; j < 2; j++) begin
               int w;
               w = 0;
               while (w < 400) begin
                  @(negedge clock);
                  if (data_ready) break;
                  w++;
               end
               check("b2b_wait", 32'(w < 400), 32'd1);
               @(posedge clock);
               #1;
               read = 1'b1;
               @(posedge clock);
               #1;
               read = 1'b0;
            end
         end
      join
      cyc(2);
      check("b2b_errs", 32'(fe_cnt - fe0 + oe_cnt - oe0), 32'd0);
      check("b2b_data", 32'(data), 32'h1FF);
      check("b2b_ready", 32'(data_ready), 32'd1);

      // Reset in the middle of data bit 4
      fe0 = fe_cnt; oe0 = oe_cnt;
      send_frame(9'h123, 1'b1, 88);
      check("mid_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("mrst_data", 32'(data), 32'd0);
      check("mrst_ready", 32'(data_ready), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_ferr", 32'(framing_error), 32'd0);
      check("mrst_oerr", 32'(overrun_error), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      cyc(4);
      send_frame(9'h0C3, 1'b1, 176);
      cyc(4);
      check("post_rst_data", 32'(data), 32'h0C3);
      check("post_rst_ready", 32'(data_ready), 32'd1);
      check("post_rst_errs", 32'(fe_cnt - fe0 + oe_cnt - oe0), 32'd0);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
